// File: rtl/axi_sram_slave_pkg.sv
// Shared constants and state encodings for the AXI-lite SRAM slave (also reused by the matrix and lsu).
package axi_sram_slave_pkg;

  localparam int unsigned CNT_W  = 5;
  localparam int unsigned RAND_W = 3;
  localparam int unsigned LFSR_W = 8;
  localparam int unsigned RESP_W = 3;

  localparam logic [LFSR_W-1:0] LFSR_SEED = 8'hA5;

  localparam logic [RESP_W-1:0] RESP_OKAY   = 3'b000;
  localparam logic [RESP_W-1:0] RESP_SLVERR = 3'b010;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_WAIT = 2'd1,
    R_RESP = 2'd2
  } rd_state_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_WAIT = 2'd1,
    W_RESP = 2'd2
  } wr_state_e;

endpackage

// File: rtl/axi_sram_lfsr.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4) used to jitter response latency when AXI_SRAM_RAND_DELAY_EN is set.
module axi_sram_lfsr
  import axi_sram_slave_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic [LFSR_W-1:0] lfsr
);

  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (en) begin
      lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign lfsr = lfsr_q;

endmodule

// File: rtl/axi_sram_slave.sv
// Word-addressed AXI-lite SRAM slave with independent read/write FSMs and programmable latency.
// Define AXI_SRAM_RAND_DELAY_EN to add 0..7 LFSR-driven extra cycles to every latency load.
module axi_sram_slave
  import axi_sram_slave_pkg::*;
#(
  parameter int unsigned          DATA_LEN  = 32,
  parameter int unsigned          ADDR_LEN  = 32,
  parameter int unsigned          STROB_LEN = 4,
  parameter int unsigned          MEM_DEPTH = 1024,
  parameter logic [ADDR_LEN-1:0]  BASE_ADDR = 32'h8000_0000,
  parameter int unsigned          RD_LAT    = 1,
  parameter int unsigned          WR_LAT    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  arvalid,
  output logic                  arready,
  input  logic [ADDR_LEN-1:0]   raddr,
  output logic                  rvalid,
  input  logic                  rready,
  output logic [RESP_W-1:0]     rresp,
  output logic [DATA_LEN-1:0]   rdata,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [ADDR_LEN-1:0]   waddr,
  input  logic                  wvalid,
  output logic                  wready,
  input  logic [STROB_LEN-1:0]  strob,
  input  logic [DATA_LEN-1:0]   wdata,
  output logic                  bvalid,
  input  logic                  bready,
  output logic [RESP_W-1:0]     bresp
);

  localparam int unsigned IDX_W   = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int unsigned BYTE_SH = $clog2(STROB_LEN);
  localparam logic [ADDR_LEN-1:0] SPAN = ADDR_LEN'(MEM_DEPTH * STROB_LEN);

  // Offset-based compare also rejects addresses below BASE_ADDR via wraparound.
  function automatic logic in_range(input logic [ADDR_LEN-1:0] a);
    return (a - BASE_ADDR) < SPAN;
  endfunction

  function automatic logic [IDX_W-1:0] to_idx(input logic [ADDR_LEN-1:0] a);
    return IDX_W'((a - BASE_ADDR) >> BYTE_SH);
  endfunction

  logic [DATA_LEN-1:0] mem [MEM_DEPTH];

  logic [RAND_W-1:0] rand_extra_c;

`ifdef AXI_SRAM_RAND_DELAY_EN
  logic [LFSR_W-1:0] lfsr_c;

  axi_sram_lfsr u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (1'b1),
    .lfsr  (lfsr_c)
  );

  assign rand_extra_c = lfsr_c[RAND_W-1:0];
`else
  assign rand_extra_c = '0;
`endif

  // ---------------- read channel ----------------
  rd_state_e           rd_state_q, rd_state_d;
  logic [CNT_W-1:0]    rd_cnt_q, rd_cnt_d;
  logic [ADDR_LEN-1:0] raddr_q, raddr_d;
  logic                arready_q, arready_d;
  logic                rvalid_q, rvalid_d;
  logic [DATA_LEN-1:0] rdata_q, rdata_d;
  logic [RESP_W-1:0]   rresp_q, rresp_d;
  logic [CNT_W-1:0]    rd_load_c;
  logic                rd_sample_c;

  always_comb begin
    rd_state_d  = rd_state_q;
    rd_cnt_d    = rd_cnt_q;
    raddr_d     = raddr_q;
    arready_d   = arready_q;
    rvalid_d    = rvalid_q;
    rdata_d     = rdata_q;
    rresp_d     = rresp_q;
    rd_sample_c = 1'b0;
    rd_load_c   = CNT_W'(RD_LAT - 1) + CNT_W'(rand_extra_c);

    case (rd_state_q)
      R_IDLE: begin
        if (arvalid && arready_q) begin
          raddr_d   = raddr;
          arready_d = 1'b0;
          if (rd_load_c == '0) begin
            rd_state_d  = R_RESP;
            rd_sample_c = 1'b1;
          end else begin
            rd_state_d = R_WAIT;
            rd_cnt_d   = rd_load_c;
          end
        end
      end
      R_WAIT: begin
        rd_cnt_d = rd_cnt_q - CNT_W'(1);
        if (rd_cnt_q <= CNT_W'(1)) begin
          rd_state_d  = R_RESP;
          rd_sample_c = 1'b1;
        end
      end
      R_RESP: begin
        if (rready) begin
          rd_state_d = R_IDLE;
          rvalid_d   = 1'b0;
          arready_d  = 1'b1;
        end
      end
      default: begin
        rd_state_d = R_IDLE;
        arready_d  = 1'b1;
        rvalid_d   = 1'b0;
      end
    endcase

    // Array is sampled on the edge that enters R_RESP; a same-edge commit is not yet visible.
    if (rd_sample_c) begin
      rvalid_d = 1'b1;
      if (in_range(raddr_d)) begin
        rdata_d = mem[to_idx(raddr_d)];
        rresp_d = RESP_OKAY;
      end else begin
        rdata_d = '0;
        rresp_d = RESP_SLVERR;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state_q <= R_IDLE;
      rd_cnt_q   <= '0;
      raddr_q    <= '0;
      arready_q  <= 1'b1;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
    end else begin
      rd_state_q <= rd_state_d;
      rd_cnt_q   <= rd_cnt_d;
      raddr_q    <= raddr_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

  // ---------------- write channel ----------------
  wr_state_e            wr_state_q, wr_state_d;
  logic [CNT_W-1:0]     wr_cnt_q, wr_cnt_d;
  logic [ADDR_LEN-1:0]  waddr_q, waddr_d;
  logic [DATA_LEN-1:0]  wdata_q, wdata_d;
  logic [STROB_LEN-1:0] strob_q, strob_d;
  logic                 aw_flag_q, aw_flag_d;
  logic                 w_flag_q, w_flag_d;
  logic                 awready_q, awready_d;
  logic                 wready_q, wready_d;
  logic                 bvalid_q, bvalid_d;
  logic [RESP_W-1:0]    bresp_q, bresp_d;
  logic [CNT_W-1:0]     wr_load_c;
  logic                 wr_commit_c;
  logic                 mem_we_c;
  logic [IDX_W-1:0]     wr_idx_c;

  always_comb begin
    wr_state_d  = wr_state_q;
    wr_cnt_d    = wr_cnt_q;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    strob_d     = strob_q;
    aw_flag_d   = aw_flag_q;
    w_flag_d    = w_flag_q;
    awready_d   = awready_q;
    wready_d    = wready_q;
    bvalid_d    = bvalid_q;
    bresp_d     = bresp_q;
    wr_commit_c = 1'b0;
    wr_load_c   = CNT_W'(WR_LAT - 1) + CNT_W'(rand_extra_c);

    case (wr_state_q)
      W_IDLE: begin
        if (awvalid && awready_q) begin
          waddr_d   = waddr;
          aw_flag_d = 1'b1;
          awready_d = 1'b0;
        end
        if (wvalid && wready_q) begin
          wdata_d  = wdata;
          strob_d  = strob;
          w_flag_d = 1'b1;
          wready_d = 1'b0;
        end
        if (aw_flag_d && w_flag_d) begin
          if (wr_load_c == '0) begin
            wr_state_d  = W_RESP;
            wr_commit_c = 1'b1;
          end else begin
            wr_state_d = W_WAIT;
            wr_cnt_d   = wr_load_c;
          end
        end
      end
      W_WAIT: begin
        wr_cnt_d = wr_cnt_q - CNT_W'(1);
        if (wr_cnt_q <= CNT_W'(1)) begin
          wr_state_d  = W_RESP;
          wr_commit_c = 1'b1;
        end
      end
      W_RESP: begin
        if (bready) begin
          wr_state_d = W_IDLE;
          bvalid_d   = 1'b0;
          aw_flag_d  = 1'b0;
          w_flag_d   = 1'b0;
          awready_d  = 1'b1;
          wready_d   = 1'b1;
        end
      end
      default: begin
        wr_state_d = W_IDLE;
        aw_flag_d  = 1'b0;
        w_flag_d   = 1'b0;
        awready_d  = 1'b1;
        wready_d   = 1'b1;
        bvalid_d   = 1'b0;
      end
    endcase

    if (wr_commit_c) begin
      bvalid_d = 1'b1;
      bresp_d  = in_range(waddr_d) ? RESP_OKAY : RESP_SLVERR;
    end

    mem_we_c = wr_commit_c && rst_n && in_range(waddr_d);
    wr_idx_c = to_idx(waddr_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state_q <= W_IDLE;
      wr_cnt_q   <= '0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      strob_q    <= '0;
      aw_flag_q  <= 1'b0;
      w_flag_q   <= 1'b0;
      awready_q  <= 1'b1;
      wready_q   <= 1'b1;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
    end else begin
      wr_state_q <= wr_state_d;
      wr_cnt_q   <= wr_cnt_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      strob_q    <= strob_d;
      aw_flag_q  <= aw_flag_d;
      w_flag_q   <= w_flag_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
    end
  end

  // Byte-lane array write; contents intentionally survive reset.
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      for (int i = 0; i < STROB_LEN; i++) begin
        if (strob_d[i]) begin
          mem[wr_idx_c][8*i +: 8] <= wdata_d[8*i +: 8];
        end
      end
    end
  end

  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;
  assign awready = awready_q;
  assign wready  = wready_q;
  assign bvalid  = bvalid_q;
  assign bresp   = bresp_q;

endmodule

// File: tb/tb_axi_sram_slave.sv
// Scoreboard bench for axi_sram_slave: directed AXI-lite traffic, monitors check every R/B beat.
module tb_axi_sram_slave;

  localparam int unsigned RD_LAT = 1;
  localparam int unsigned WR_LAT = 3;
  localparam logic [2:0]  OKAY   = 3'b000;
  localparam logic [2:0]  SLVERR = 3'b010;

  logic        clk;
  logic        rst_n;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] raddr, rdata;
  logic [2:0]  rresp, bresp;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [31:0] waddr, wdata;
  logic [3:0]  strob;

  int checks = 0;
  int errors = 0;
  int rd_done = 0;
  int wr_done = 0;

  logic [34:0] rd_q [$];
  logic [2:0]  wr_q [$];
  logic [34:0] re;
  logic [2:0]  be;

  axi_sram_slave #(.RD_LAT(RD_LAT), .WR_LAT(WR_LAT)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .arvalid (arvalid),
    .arready (arready),
    .raddr   (raddr),
    .rvalid  (rvalid),
    .rready  (rready),
    .rresp   (rresp),
    .rdata   (rdata),
    .awvalid (awvalid),
    .awready (awready),
    .waddr   (waddr),
    .wvalid  (wvalid),
    .wready  (wready),
    .strob   (strob),
    .wdata   (wdata),
    .bvalid  (bvalid),
    .bready  (bready),
    .bresp   (bresp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Response monitors: pop the expected beat whenever a handshake is about to happen.
  always @(negedge clk) begin
    if (rst_n && rvalid && rready) begin
      if (rd_q.size() == 0) begin
        chk("r_unexpected", 1, 0);
      end else begin
        re = rd_q.pop_front();
        chk("rdata", rdata, re[31:0]);
        chk("rresp", rresp, re[34:32]);
      end
      rd_done++;
    end
    if (rst_n && bvalid && bready) begin
      if (wr_q.size() == 0) begin
        chk("b_unexpected", 1, 0);
      end else begin
        be = wr_q.pop_front();
        chk("bresp", bresp, be);
      end
      wr_done++;
    end
  end

  task automatic wait_rd(input int target);
    bit ok;
    ok = 0;
    for (int k = 0; k < 60 && !ok; k++) begin
      @(posedge clk);
      ok = (rd_done >= target);
    end
    #1;
    chk("rd_resp_timeout", ok, 1);
  endtask

  task automatic wait_wr(input int target);
    bit ok;
    ok = 0;
    for (int k = 0; k < 60 && !ok; k++) begin
      @(posedge clk);
      ok = (wr_done >= target);
    end
    #1;
    chk("wr_resp_timeout", ok, 1);
  endtask

  task automatic do_read(input logic [31:0] a, input logic [31:0] ed, input logic [2:0] er);
    int n0;
    bit ok;
    n0 = rd_done;
    rd_q.push_back({er, ed});
    @(posedge clk); #1;
    arvalid = 1'b1;
    raddr   = a;
    ok = 0;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      ok = arready;
    end
    chk("ar_handshake", ok, 1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    for (int k = 1; k <= RD_LAT; k++) begin
      @(negedge clk);
      chk("rd_latency", rvalid, (k == RD_LAT));
    end
    wait_rd(n0 + 1);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int gap, input logic [2:0] er);
    int n0;
    bit ok;
    n0 = wr_done;
    wr_q.push_back(er);
    @(posedge clk); #1;
    awvalid = 1'b1;
    waddr   = a;
    if (gap == 0) begin
      wvalid = 1'b1;
      wdata  = d;
      strob  = s;
    end
    ok = 0;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      ok = awready && (gap > 0 || wready);
    end
    chk("aw_handshake", ok, 1);
    @(posedge clk); #1;
    awvalid = 1'b0;
    wvalid  = 1'b0;
    if (gap > 0) begin
      repeat (gap) @(posedge clk);
      #1;
      chk("b_before_w", bvalid, 0);
      wvalid = 1'b1;
      wdata  = d;
      strob  = s;
      ok = 0;
      for (int k = 0; k < 50 && !ok; k++) begin
        @(negedge clk);
        ok = wready;
      end
      chk("w_handshake", ok, 1);
      @(posedge clk); #1;
      wvalid = 1'b0;
    end
    for (int k = 1; k <= WR_LAT; k++) begin
      @(negedge clk);
      chk("wr_latency", bvalid, (k == WR_LAT));
    end
    wait_wr(n0 + 1);
  endtask

  initial begin
    int hs;
    int n0;
    rst_n = 1'b0; arvalid = 1'b0; raddr = '0; rready = 1'b1;
    awvalid = 1'b0; waddr = '0; wvalid = 1'b0; wdata = '0; strob = '0; bready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_arready", arready, 1);
    chk("rst_awready", awready, 1);
    chk("rst_wready", wready, 1);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_rresp", rresp, 0);
    chk("rst_bresp", bresp, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Preload through the bus.
    do_write(32'h8000_0000, 32'h0123_4567, 4'hF, 0, OKAY);
    do_write(32'h8000_0004, 32'h1122_3344, 4'hF, 0, OKAY);
    do_write(32'h8000_0008, 32'h0000_000A, 4'hF, 0, OKAY);
    do_write(32'h8000_000C, 32'h3333_3333, 4'hF, 0, OKAY);

    // Basic read of word 0.
    do_read(32'h8000_0000, 32'h0123_4567, OKAY);

    // AW leads W by two cycles, partial strobe.
    do_write(32'h8000_0004, 32'hDEAD_BEEF, 4'b0011, 2, OKAY);
    do_read(32'h8000_0004, 32'h1122_BEEF, OKAY);

    // Out-of-range on both channels; 0x8000_1000 would alias word 0 without the range check.
    do_read(32'h7FFF_FFFC, 32'h0, SLVERR);
    do_write(32'h8000_1000, 32'hFFFF_FFFF, 4'hF, 0, SLVERR);
    do_read(32'h8000_0000, 32'h0123_4567, OKAY);

    // Zero strobe commits nothing but answers OKAY.
    do_write(32'h8000_0000, 32'hFFFF_FFFF, 4'h0, 0, OKAY);
    do_read(32'h8000_0000, 32'h0123_4567, OKAY);

    // Backpressure on R: response held, AR blocked.
    n0 = rd_done;
    rready = 1'b0;
    rd_q.push_back({OKAY, 32'h1122_BEEF});
    @(posedge clk); #1;
    arvalid = 1'b1;
    raddr   = 32'h8000_0004;
    @(negedge clk);
    chk("bp_arready_hs", arready, 1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_rvalid", rvalid, 1);
      chk("bp_rdata", rdata, 32'h1122_BEEF);
      chk("bp_arready", arready, 0);
    end
    @(posedge clk); #1;
    rready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_arready_after", arready, 1);
    chk("bp_rvalid_after", rvalid, 0);
    wait_rd(n0 + 1);

    // Back-to-back reads: one AR handshake every two cycles.
    n0 = rd_done;
    repeat (3) rd_q.push_back({OKAY, 32'h0123_4567});
    hs = 0;
    @(posedge clk); #1;
    arvalid = 1'b1;
    raddr   = 32'h8000_0000;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (arready) hs++;
    end
    @(posedge clk); #1;
    arvalid = 1'b0;
    chk("b2b_handshakes", hs, 3);
    wait_rd(n0 + 3);

    // Collision: read sample and write commit on the same edge to word 2.
    n0 = wr_done;
    hs = rd_done;
    wr_q.push_back(OKAY);
    rd_q.push_back({OKAY, 32'h0000_000A});
    @(posedge clk); #1;
    awvalid = 1'b1; wvalid = 1'b1;
    waddr = 32'h8000_0008; wdata = 32'h0000_000B; strob = 4'hF;
    @(negedge clk);
    chk("col_aw_w_ready", {awready, wready}, 2'b11);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    for (int k = 2; k < WR_LAT; k++) begin
      @(posedge clk); #1;
    end
    arvalid = 1'b1;
    raddr   = 32'h8000_0008;
    @(negedge clk);
    chk("col_arready", arready, 1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    wait_rd(hs + 1);
    wait_wr(n0 + 1);
    do_read(32'h8000_0008, 32'h0000_000B, OKAY);

    // Reset while the write waits out its latency: nothing commits.
    @(posedge clk); #1;
    awvalid = 1'b1; wvalid = 1'b1;
    waddr = 32'h8000_000C; wdata = 32'h4444_4444; strob = 4'hF;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    chk("wwait_bvalid", bvalid, 0);
    chk("wwait_awready", awready, 0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_bvalid", bvalid, 0);
    chk("midrst_awready", awready, 1);
    chk("midrst_wready", wready, 1);
    chk("midrst_rdata", rdata, 0);
    repeat (WR_LAT + 1) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (WR_LAT + 1) @(negedge clk);
    chk("postrst_bvalid", bvalid, 0);
    do_read(32'h8000_000C, 32'h3333_3333, OKAY);

    repeat (3) @(posedge clk);
    chk("rd_q_empty", rd_q.size(), 0);
    chk("wr_q_empty", wr_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
